conv_pos_gen: RTL and testbench

//   Producer side of the kernel_pos_t interface. Walks a configured WxH image in raster order.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/conv_pos_axis_cnt.sv | 71 +++++++
 rtl/conv_pos_gen.sv | 172 +++++++++++++++++
 tb/tb_conv_pos_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types for the convolution front end: image limits, axis counter types,
// the 5x5 tap-inside-image mask and the position-generator state encoding.
package conv_pkg;

    localparam int unsigned IMAGE_MAX_W = 4096;
    localparam int unsigned IMAGE_MAX_H = 4096;
    localparam int unsigned COL_W       = $clog2(IMAGE_MAX_W + 1);
    localparam int unsigned ROW_W       = $clog2(IMAGE_MAX_H + 1);

    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;

    // 1 = tap lies inside the image, 0 = off-image (datapath pads)
    typedef struct packed {
        logic w2;
        logic w1;
        logic e1;
        logic e2;
        logic n2;
        logic n1;
        logic s1;
        logic s2;
    } kernel_pos_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pos_gen_state_t;

endpackage

// File: rtl/conv_pos_axis_cnt.sv
// One image axis: position counter, latched axis size and registered
// boundary flags (lo = towards index 0, hi = towards size-1).
// All flags are forced low while the generator is not producing descriptors.
module conv_pos_axis_cnt #(
    parameter int unsigned SIZE_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic              act_d,
    input  logic [SIZE_W-1:0] size_in,
    output logic              lo1_q,
    output logic              lo2_q,
    output logic              hi1_q,
    output logic              hi2_q,
    output logic              first_c,
    output logic              last_c
);

    // Two extra bits so cnt+3 cannot wrap even at the maximum size
    localparam int unsigned EXT_W = SIZE_W + 2;

    logic [SIZE_W-1:0] cnt_q, cnt_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic              last_q;
    logic              lo1_d, lo2_d, hi1_d, hi2_d;
    logic [EXT_W-1:0]  cnt_x, size_x;

    // Next count, next size and the flags that describe the next position
    always_comb begin
        size_d = size_q;
        cnt_d  = cnt_q;
        if (load) begin
            size_d = size_in;
            cnt_d  = '0;
        end else if (adv) begin
            cnt_d = last_q ? '0 : cnt_q + SIZE_W'(1);
        end
        cnt_x   = EXT_W'(cnt_d);
        size_x  = EXT_W'(size_d);
        lo1_d   = act_d && (cnt_x >= EXT_W'(1));
        lo2_d   = act_d && (cnt_x >= EXT_W'(2));
        hi1_d   = act_d && ((cnt_x + EXT_W'(2)) <= size_x);
        hi2_d   = act_d && ((cnt_x + EXT_W'(3)) <= size_x);
        first_c = act_d && (cnt_d == '0);
        last_c  = act_d && ((cnt_x + EXT_W'(1)) == size_x);
    end

    // Axis state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            size_q <= '0;
            last_q <= 1'b0;
            lo1_q  <= 1'b0;
            lo2_q  <= 1'b0;
            hi1_q  <= 1'b0;
            hi2_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            size_q <= size_d;
            last_q <= last_c;
            lo1_q  <= lo1_d;
            lo2_q  <= lo2_d;
            hi1_q  <= hi1_d;
            hi2_q  <= hi2_d;
        end
    end

endmodule

// File: rtl/conv_pos_gen.sv
// Raster-order window-position generator for the 5x5 convolution datapath.
// Emits one kernel_pos_t descriptor per centre pixel over valid/ready.
// Optional build macro CONV_POS_GEN_CFG_CHECK_EN: rejects illegal frame sizes
// at start and reports them on cfg_err.
module conv_pos_gen
    import conv_pkg::*;
(
`ifdef CONV_POS_GEN_CFG_CHECK_EN
    output logic        cfg_err,
`endif
    input  logic        clk,
    input  logic        rst,
    input  col_t        cfg_w,
    input  row_t        cfg_h,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        out_vld,
    input  logic        out_rdy,
    output kernel_pos_t out_pos,
    output logic        out_sol,
    output logic        out_eol,
    output logic        out_sof,
    output logic        out_eof
);

    pos_gen_state_t state_q, state_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic vld_q, vld_d;
    logic sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;
    logic start_acc, act_d, xfer, cfg_ok;
    logic col_lo1, col_lo2, col_hi1, col_hi2, col_first_c, col_last_c;
    logic row_lo1, row_lo2, row_hi1, row_hi2, row_first_c, row_last_c;

    assign xfer = vld_q && out_rdy;

`ifdef CONV_POS_GEN_CFG_CHECK_EN
    logic cfg_err_q, cfg_err_d;

    // Frame size must be non-zero and within the counter range
    assign cfg_ok = (cfg_w != '0) && (cfg_h != '0) &&
                    (cfg_w <= COL_W'(IMAGE_MAX_W)) && (cfg_h <= ROW_W'(IMAGE_MAX_H));

    // Rejected-start pulse
    always_comb begin
        cfg_err_d = 1'b0;
        if ((state_q == IDLE) && start && !cfg_ok) begin
            cfg_err_d = 1'b1;
        end
    end

    // Rejected-start register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;
`else
    assign cfg_ok = 1'b1;
`endif

    // Frame FSM and next values of the registered stream outputs
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && cfg_ok) begin
                    state_d   = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                if (xfer && eof_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        act_d  = (state_d == RUN);
        busy_d = act_d;
        vld_d  = act_d;
        sol_d  = col_first_c;
        eol_d  = col_last_c;
        sof_d  = col_first_c && row_first_c;
        eof_d  = col_last_c && row_last_c;
    end

    // Control and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            sol_q   <= 1'b0;
            eol_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            sol_q   <= sol_d;
            eol_q   <= eol_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    // Column axis advances on every transfer, maps to west/east taps
    conv_pos_axis_cnt #(.SIZE_W(COL_W)) u_col (
        .clk     (clk),
        .rst     (rst),
        .load    (start_acc),
        .adv     (xfer),
        .act_d   (act_d),
        .size_in (cfg_w),
        .lo1_q   (col_lo1),
        .lo2_q   (col_lo2),
        .hi1_q   (col_hi1),
        .hi2_q   (col_hi2),
        .first_c (col_first_c),
        .last_c  (col_last_c)
    );

    // Row axis advances on end-of-line transfers, maps to north/south taps
    conv_pos_axis_cnt #(.SIZE_W(ROW_W)) u_row (
        .clk     (clk),
        .rst     (rst),
        .load    (start_acc),
        .adv     (xfer && eol_q),
        .act_d   (act_d),
        .size_in (cfg_h),
        .lo1_q   (row_lo1),
        .lo2_q   (row_lo2),
        .hi1_q   (row_hi1),
        .hi2_q   (row_hi2),
        .first_c (row_first_c),
        .last_c  (row_last_c)
    );

    // Mask is a plain regrouping of the registered axis flags
    always_comb begin
        out_pos    = '0;
        out_pos.w2 = col_lo2;
        out_pos.w1 = col_lo1;
        out_pos.e1 = col_hi1;
        out_pos.e2 = col_hi2;
        out_pos.n2 = row_lo2;
        out_pos.n1 = row_lo1;
        out_pos.s1 = row_hi1;
        out_pos.s2 = row_hi2;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign out_vld = vld_q;
    assign out_sol = sol_q;
    assign out_eol = eol_q;
    assign out_sof = sof_q;
    assign out_eof = eof_q;

endmodule

// File: tb/tb_conv_pos_gen.sv
// Self-checking bench for conv_pos_gen: raster-order descriptors compared
// against a per-pixel arithmetic model, with random stalls and mid-frame
// start/cfg noise. Honours CONV_POS_GEN_CFG_CHECK_EN when defined.
module tb_conv_pos_gen;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        out_rdy = 1'b0;
    col_t        cfg_w = '0;
    row_t        cfg_h = '0;
    logic        busy, done, out_vld, out_sol, out_eol, out_sof, out_eof;
    kernel_pos_t out_pos;
`ifdef CONV_POS_GEN_CFG_CHECK_EN
    logic        cfg_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_pos_gen dut (
`ifdef CONV_POS_GEN_CFG_CHECK_EN
        .cfg_err (cfg_err),
`endif
        .clk     (clk),
        .rst     (rst),
        .cfg_w   (cfg_w),
        .cfg_h   (cfg_h),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_pos (out_pos),
        .out_sol (out_sol),
        .out_eol (out_eol),
        .out_sof (out_sof),
        .out_eof (out_eof)
    );

    // Expected {mask, sol, eol, sof, eof} for centre (r,c) of a w x h image
    function automatic logic [11:0] model(input int r, input int c, input int w, input int h);
        logic [7:0] m;
        m = {c >= 2, c >= 1, c + 1 <= w - 1, c + 2 <= w - 1,
             r >= 2, r >= 1, r + 1 <= h - 1, r + 2 <= h - 1};
        return {m, c == 0, c == w - 1, (r == 0) && (c == 0), (r == h - 1) && (c == w - 1)};
    endfunction

    // Drive one whole frame and check every transferred descriptor in order
    task automatic run_frame(input int w, input int h, input bit stall);
        int r, c, n, cyc;
        logic [11:0] cur, exp_v, snap;
        bit stalled;
        cfg_w = col_t'(w);
        cfg_h = row_t'(h);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (out_vld !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_vld %0dx%0d got vld=%b busy=%b need 1 1", w, h, out_vld, busy);
        end
        r = 0; c = 0; n = 0; cyc = 0; stalled = 0; snap = '0;
        while (n < w * h && cyc < 4 * w * h + 100) begin
            cur = {out_pos, out_sol, out_eol, out_sof, out_eof};
            if (out_vld !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL vld_drop %0dx%0d at r=%0d c=%0d got vld=%b need 1", w, h, r, c, out_vld);
                break;
            end
            if (stalled) begin
                checks++;
                if (cur !== snap) begin
                    errors++;
                    $display("FAIL stall_hold r=%0d c=%0d got %h need %h", r, c, cur, snap);
                end
            end
            out_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start   = 1'($urandom_range(0, 1));
            cfg_w   = col_t'($urandom_range(0, 20));
            cfg_h   = row_t'($urandom_range(0, 20));
            if (out_rdy) begin
                exp_v = model(r, c, w, h);
                checks++;
                if (cur !== exp_v) begin
                    errors++;
                    $display("FAIL desc %0dx%0d r=%0d c=%0d got %h need %h", w, h, r, c, cur, exp_v);
                end
                n++;
                if (c == w - 1) begin
                    c = 0;
                    r++;
                end else begin
                    c++;
                end
                stalled = 0;
            end else begin
                snap    = cur;
                stalled = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start   = 1'b0;
        out_rdy = 1'b0;
        checks++;
        if (n != w * h) begin
            errors++;
            $display("FAIL count %0dx%0d got %0d transfers need %0d", w, h, n, w * h);
        end
        checks++;
        if ({done, busy, out_vld} !== 3'b100) begin
            errors++;
            $display("FAIL frame_end %0dx%0d got done/busy/vld=%b need 100", w, h, {done, busy, out_vld});
        end
`ifdef CONV_POS_GEN_CFG_CHECK_EN
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_in_run got %b need 0", cfg_err);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got %b need 0", done);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, out_vld, out_pos, out_sol, out_eol, out_sof, out_eof} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state got %h need 0",
                     {busy, done, out_vld, out_pos, out_sol, out_eol, out_sof, out_eof});
        end
    endtask

    task automatic test_5x5();
        run_frame(5, 5, 1'b0);
    endtask

    task automatic test_w1h3();
        run_frame(1, 3, 1'b0);
    endtask

    task automatic test_wide();
        run_frame(4096, 2, 1'b0);
    endtask

    task automatic test_stall();
        run_frame(4, 4, 1'b1);
    endtask

    task automatic test_random_sizes();
        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(1, 7), $urandom_range(1, 6), 1'b1);
        end
        run_frame(1, 1, 1'b1);
    endtask

    task automatic test_reset_mid();
        cfg_w = col_t'(5);
        cfg_h = row_t'(5);
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        out_rdy = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (out_vld !== 1'b1) begin
            errors++;
            $display("FAIL mid_vld got %b need 1", out_vld);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_vld, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got vld/busy/done=%b need 000", {out_vld, busy, done});
        end
        @(posedge clk); #1;
        rst     = 1'b0;
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_vld, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset got vld/busy/done=%b need 000", {out_vld, busy, done});
            end
        end
        run_frame(5, 5, 1'b0);
    endtask

`ifdef CONV_POS_GEN_CFG_CHECK_EN
    task automatic test_cfg_reject(input int w, input int h);
        cfg_w = col_t'(w);
        cfg_h = row_t'(h);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({cfg_err, busy, out_vld} !== 3'b100) begin
            errors++;
            $display("FAIL cfg_reject w=%0d h=%0d got err/busy/vld=%b need 100", w, h, {cfg_err, busy, out_vld});
        end
        @(posedge clk); #1;
        checks++;
        if ({cfg_err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL cfg_err_pulse got err/busy=%b need 00", {cfg_err, busy});
        end
    endtask

    task automatic test_cfg_check();
        test_cfg_reject(0, 3);
        test_cfg_reject(4097, 3);
        test_cfg_reject(3, 0);
        test_cfg_reject(3, 4097);
        run_frame(3, 2, 1'b1);
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_5x5();
        test_w1h3();
        test_wide();
        test_stall();
        test_random_sizes();
        test_reset_mid();
`ifdef CONV_POS_GEN_CFG_CHECK_EN
        test_cfg_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
